// File: rtl/pipelined_bitwise_logic_unit.sv
// Two-stage valid/ready bitwise logic unit: eight selectable ops, optional
// accumulator operand with write-back, and zero/ones/parity flags on the result.
module pipelined_bitwise_logic_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [WIDTH-1:0] acc_q
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  logic             s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0] s1A_q, s1A_d;
  logic [WIDTH-1:0] s1B_q, s1B_d;
  op_e              s1Op_q, s1Op_d;
  logic             s1AccEn_q, s1AccEn_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_d;

  logic             adv2;
  logic             inXfer;
  logic [WIDTH-1:0] accEff;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opRes;

  // A clear in the same cycle as an accumulating advance feeds ACC_INIT into the op.
  always_comb begin
    adv2     = s1Valid_q && (!outValid_q || out_ready);
    in_ready = !s1Valid_q || adv2;
    inXfer   = in_valid && in_ready;
    accEff   = acc_clr ? ACC_INIT : acc_q;
    opA      = s1AccEn_q ? accEff : s1A_q;
  end

  always_comb begin
    opRes = s1B_q;
    unique case (s1Op_q)
      OP_AND:   opRes = opA & s1B_q;
      OP_OR:    opRes = opA | s1B_q;
      OP_XOR:   opRes = opA ^ s1B_q;
      OP_NAND:  opRes = ~(opA & s1B_q);
      OP_NOR:   opRes = ~(opA | s1B_q);
      OP_XNOR:  opRes = ~(opA ^ s1B_q);
      OP_ANDN:  opRes = opA & ~s1B_q;
      OP_PASSB: opRes = s1B_q;
    endcase
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Op_d     = s1Op_q;
    s1AccEn_d  = s1AccEn_q;
    outValid_d = outValid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ones_d     = ones_q;
    parity_d   = parity_q;
    acc_d      = acc_q;

    if (inXfer) begin
      s1Valid_d = 1'b1;
      s1A_d     = i0;
      s1B_d     = i1;
      s1Op_d    = op_e'(op);
      s1AccEn_d = acc_en;
    end else if (adv2) begin
      s1Valid_d = 1'b0;
    end

    // Output stage refills from stage 1 when it advances, empties on a bare pop.
    if (adv2 || out_ready) begin
      outValid_d = s1Valid_q;
    end
    if (adv2) begin
      result_d = opRes;
      zero_d   = (opRes == '0);
      ones_d   = &opRes;
      parity_d = ^opRes;
    end

    if (adv2 && s1AccEn_q) begin
      acc_d = opRes;
    end else if (acc_clr) begin
      acc_d = ACC_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Op_q     <= OP_AND;
      s1AccEn_q  <= 1'b0;
      outValid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ones_q     <= 1'b0;
      parity_q   <= 1'b0;
      acc_q      <= ACC_INIT;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Op_q     <= s1Op_d;
      s1AccEn_q  <= s1AccEn_d;
      outValid_q <= outValid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
      parity_q   <= parity_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = outValid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign parity    = parity_q;

endmodule
